mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline, sitting between EXE and WB.
- Consumes the EXE->MEM bus and drives a synchronous data RAM: one-cycle read latency, byte write enables.
- Performs byte/half/word load extraction and store lane steering, and detects misaligned addresses.
- Produces the 124-bit MEM->WB bus that the writeback stage unpacks.

Parameters:
- EM_W, 161, EXE->MEM bus width.
- MW_W, 124, MEM->WB bus width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- MEM_valid  in  1  stage holds a valid instruction
- EXE_MEM_bus_r  in  161  layout {ld, st, size[1:0] (0 byte, 1 half, 2 word), sgn, store_data[31:0], then the MEM->WB layout with exe_result in the mem_result slot}
- WB_allow_in  in  1  WB accepts this cycle
- cancel  in  1  syscall/eret flush from WB
- dm_rdata  in  32  RAM read data, valid the cycle after address
- dm_addr  out  32  {exe_result[31:2], 2'b00}
- dm_wen  out  4  byte write enables
- dm_wdata  out  32  lane-steered store data
- MEM_over  out  1  stage result ready
- MEM_WB_bus  out  124  {wen, wdest[4:0], mem_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, break, fetch_error, inst_reserved, raddr_error, waddr_error, overflow, pc}
- MEM_wdest  out  5  wdest & {5{MEM_valid}}, for hazard detection

Behaviour:
- Reset (resetn low at posedge): load_done_r=0, store_issued_r=0, load_data_r=0. While resetn is low, dm_wen=0 and MEM_over=0.
- Advance condition: adv = MEM_over & WB_allow_in. adv clears both flags next cycle.
- Suppression: any upstream exception bit (fetch_error, inst_reserved, overflow, syscall, eret, break) suppresses the memory access. MEM_over = MEM_valid, the access behaves as non-memory, and bits pass through.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - Load: raddr_error=1. Store: waddr_error=1.
  - Forces wen=0 and dm_wen=0; MEM_over=MEM_valid in the same cycle.
- Load, two-cycle:
  - Cycle 0: address presented, MEM_over=0.
  - Posedge: load_done_r<=1 and load_data_r<=dm_rdata is captured on the following posedge, so the stage presents the result in cycle 1.
  - Cycle 1+: MEM_over=1; mem_result is extracted from dm_rdata in the first ready cycle, then from load_data_r while stalled.
  - Extraction: byte lane addr[1:0], half lane addr[1]; sign-extend if sgn=1, else zero-extend.
- Store:
  - dm_wen = MEM_valid & st & !err & !store_issued_r & !cancel.
  - Written exactly once: store_issued_r<=1 on issue if !adv.
  - MEM_over=1 in the issue cycle.
  - Byte: dm_wen=4'b0001<<addr[1:0], data {4{b}}. Half: 0011 or 1100 by addr[1], data {2{h}}. Word: 1111.
- Non-memory instructions: MEM_over=MEM_valid; mem_result=exe_result.
- Cancel: same cycle, no dm_wen and flags clear at posedge; a load in flight is abandoned.
- Stall during a load: with load_done_r=1 and WB_allow_in=0, the result is held stable and no re-read is needed.

Optional Feature:
- MEM_ADDR_EXC_EN defined: misalignment detection as above.
- Undefined: raddr_error and waddr_error are tied to 0. Low address bits still steer lanes, and misaligned half/word use lanes addr[1] / all four (addr[1:0] ignored for word).

Decomposition:
- mem_pkg: bus widths, field offsets, size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
- Sub-module mem_align (combinational): store lane steering, load extraction, misalign detect. mem_stage holds the flags, handshake and bus pack.

Test Plan:
- lw at 0x100, RAM word 0x11223344, WB_allow_in=1 -> MEM_over 0 then 1; mem_result=0x11223344; wen passes through.
- lb sgn=1 at 0x103, RAM 0x80FF7F00 -> mem_result=0xFFFFFF80. lbu at 0x101 -> 0x0000007F.
- sh 0xABCD at 0x202, WB_allow_in low 3 cycles -> dm_wen=1100 with data 0xABCDABCD for exactly one cycle; MEM_over held 1.
- lw at 0x101 with MEM_ADDR_EXC_EN -> raddr_error=1, wen=0, MEM_over same cycle. sw at 0x102 -> waddr_error=1, dm_wen never asserted.
- sb with cancel=1 in issue cycle -> dm_wen=0; next instruction (addu) passes exe_result unchanged.
- resetn low during load cycle 1 -> MEM_over=0, dm_wen=0, load_done_r=0 after the edge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: bus widths, field offsets
// within the EXE->MEM and MEM->WB buses, access-size encodings, load extension.
package mem_pkg;

  localparam int EM_W = 161;
  localparam int MW_W = 124;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // MEM->WB bus, bit offsets from the LSB
  localparam int MW_PC_LO       = 0;
  localparam int MW_OVERFLOW    = 32;
  localparam int MW_WADDR_ERR   = 33;
  localparam int MW_RADDR_ERR   = 34;
  localparam int MW_INST_RSV    = 35;
  localparam int MW_FETCH_ERR   = 36;
  localparam int MW_BREAK       = 37;
  localparam int MW_ERET        = 38;
  localparam int MW_SYSCALL     = 39;
  localparam int MW_CP0R_LO     = 40;
  localparam int MW_LO_RES_LO   = 54;
  localparam int MW_MEM_RES_LO  = 86;
  localparam int MW_WDEST_LO    = 118;
  localparam int MW_WEN         = 123;

  // EXE->MEM bus: memory-control fields sit above the MEM->WB layout
  localparam int EM_SDATA_LO    = 124;
  localparam int EM_SGN         = 156;
  localparam int EM_SIZE_LO     = 157;
  localparam int EM_ST          = 159;
  localparam int EM_LD          = 160;

  // Sign/zero extension of a byte (low 8 bits of v) or a halfword
  function automatic logic [31:0] load_ext(input logic [15:0] v,
                                           input logic        is_half,
                                           input logic        sgn);
    logic fill;
    fill = sgn & (is_half ? v[15] : v[7]);
    return is_half ? {{16{fill}}, v} : {{24{fill}}, v[7:0]};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte-enable/data steering, load extraction,
// and misalignment detection (only when MEM_ADDR_EXC_EN is defined).
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  lane_wen,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    lane_wen   = 4'b1111;
    lane_wdata = store_data;
    load_val   = rdata;
    case (size)
      SZ_BYTE: begin
        lane_wen   = 4'b0001 << addr_lo;
        lane_wdata = {4{store_data[7:0]}};
        load_val   = load_ext({8'h00, byte_sel}, 1'b0, sgn);
      end
      SZ_HALF: begin
        lane_wen   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data[15:0]}};
        load_val   = load_ext(half_sel, 1'b1, sgn);
      end
      default: begin
        // Word (and the unused encoding): all lanes, addr_lo ignored
        lane_wen   = 4'b1111;
        lane_wdata = store_data;
        load_val   = rdata;
      end
    endcase
  end

`ifdef MEM_ADDR_EXC_EN
  assign misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                      ((size == SZ_WORD) && (addr_lo != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EXE and WB: drives the synchronous data
// RAM, tracks load/store progress, packs the MEM->WB bus. Option: MEM_ADDR_EXC_EN.
//
// Handshake: the stage holds an instruction while MEM_valid=1; MEM_over=1 says
// its result is ready, and it retires on any cycle where MEM_over & WB_allow_in.
module mem_stage
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          MEM_valid,
  input  logic [160:0]  EXE_MEM_bus_r,
  input  logic          WB_allow_in,
  input  logic          cancel,
  input  logic [31:0]   dm_rdata,
  output logic [31:0]   dm_addr,
  output logic [3:0]    dm_wen,
  output logic [31:0]   dm_wdata,
  output logic          MEM_over,
  output logic [123:0]  MEM_WB_bus,
  output logic [4:0]    MEM_wdest
);

  logic [MW_W-1:0] mw_in;
  logic            ld_in;
  logic            st_in;
  logic [1:0]      size_in;
  logic            sgn_in;
  logic [31:0]     store_data;
  logic [31:0]     exe_result;
  logic            wen_in;
  logic [4:0]      wdest;

  logic            exc_any;
  logic            mem_ld;
  logic            mem_st;
  logic            misaligned;
  logic            raddr_err;
  logic            waddr_err;
  logic            is_load;
  logic            is_store;
  logic            adv;

  logic [3:0]      lane_wen;
  logic [31:0]     lane_wdata;
  logic [31:0]     load_val;
  logic [31:0]     ld_src;
  logic [31:0]     mem_result;

  logic            load_done_q, load_done_d;
  logic            load_held_q, load_held_d;
  logic [31:0]     load_data_q, load_data_d;
  logic            store_issued_q, store_issued_d;

  assign mw_in      = EXE_MEM_bus_r[MW_W-1:0];
  assign ld_in      = EXE_MEM_bus_r[EM_LD];
  assign st_in      = EXE_MEM_bus_r[EM_ST];
  assign size_in    = EXE_MEM_bus_r[EM_SIZE_LO +: 2];
  assign sgn_in     = EXE_MEM_bus_r[EM_SGN];
  assign store_data = EXE_MEM_bus_r[EM_SDATA_LO +: 32];
  assign exe_result = mw_in[MW_MEM_RES_LO +: 32];
  assign wen_in     = mw_in[MW_WEN];
  assign wdest      = mw_in[MW_WDEST_LO +: 5];

  // An instruction already carrying an exception never touches memory
  assign exc_any = mw_in[MW_FETCH_ERR] | mw_in[MW_INST_RSV] | mw_in[MW_OVERFLOW] |
                   mw_in[MW_SYSCALL]   | mw_in[MW_ERET]     | mw_in[MW_BREAK];
  assign mem_ld  = ld_in & ~exc_any;
  assign mem_st  = st_in & ~exc_any;

  assign raddr_err = mem_ld & misaligned;
  assign waddr_err = mem_st & misaligned;
  assign is_load   = mem_ld & ~misaligned;
  assign is_store  = mem_st & ~misaligned;

  // After the first ready cycle the captured word is used so a stall never
  // depends on the RAM output staying put.
  assign ld_src = load_held_q ? load_data_q : dm_rdata;

  mem_align u_align (
    .addr_lo    (exe_result[1:0]),
    .size       (size_in),
    .sgn        (sgn_in),
    .store_data (store_data),
    .rdata      (ld_src),
    .lane_wen   (lane_wen),
    .lane_wdata (lane_wdata),
    .load_val   (load_val),
    .misaligned (misaligned)
  );

  assign MEM_over = resetn & MEM_valid & (~is_load | load_done_q);
  assign adv      = MEM_over & WB_allow_in;

  assign dm_addr  = {exe_result[31:2], 2'b00};
  assign dm_wdata = lane_wdata;
  assign dm_wen   = (resetn & MEM_valid & is_store & ~store_issued_q & ~cancel) ?
                    lane_wen : 4'b0000;

  assign mem_result = is_load ? load_val : exe_result;
  assign MEM_wdest  = wdest & {5{MEM_valid}};

  always_comb begin
    load_done_d    = MEM_valid & is_load & ~adv & ~cancel;
    load_held_d    = MEM_valid & is_load & load_done_q & ~adv & ~cancel;
    load_data_d    = (load_done_q & ~load_held_q) ? dm_rdata : load_data_q;
    store_issued_d = MEM_valid & is_store & ~adv & ~cancel;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      load_done_q    <= 1'b0;
      load_held_q    <= 1'b0;
      load_data_q    <= 32'h0;
      store_issued_q <= 1'b0;
    end else begin
      load_done_q    <= load_done_d;
      load_held_q    <= load_held_d;
      load_data_q    <= load_data_d;
      store_issued_q <= store_issued_d;
    end
  end

  always_comb begin
    MEM_WB_bus                         = mw_in;
    MEM_WB_bus[MW_MEM_RES_LO +: 32]    = mem_result;
    MEM_WB_bus[MW_WEN]                 = wen_in & ~(raddr_err | waddr_err);
    MEM_WB_bus[MW_RADDR_ERR]           = raddr_err;
    MEM_WB_bus[MW_WADDR_ERR]           = waddr_err;
  end

endmodule
